truth_table_scanner: RTL



---
 rtl/truth_table_scanner_pkg.sv | 29 ++
 rtl/truth_table_scanner_if.sv | 46 ++++
 rtl/truth_table_scanner_settle_timer.sv | 30 +++
 rtl/truth_table_scanner.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/truth_table_scanner_pkg.sv
// scanner_pkg: shared types and sizing helpers for truth_table_scanner.
//   state_t   : scan FSM states
//   TABLE_W   : table width for the default 3-input configuration
//   table_w() : table width for an arbitrary input count
//   settle_w(): width of the settle down-counter
package scanner_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int N_IN_DEF = 3;
  localparam int TABLE_W  = 2**N_IN_DEF;

  function automatic int table_w(input int n);
    return 2**n;
  endfunction

  // The counter holds SETTLE_CYCLES, so it needs clog2(SETTLE_CYCLES+1) bits.
  // The result is clamped to 1 so a bad parameter still elaborates far
  // enough to reach the explicit range check in the top.
  function automatic int settle_w(input int s);
    return (s < 1) ? 1 : $clog2(s + 1);
  endfunction

endpackage

// File: rtl/truth_table_scanner_if.sv
// truth_table_scanner_if: stimulus/capture bus between the scanner and the
// bench or board logic that owns the circuit-under-test.
//   start            : single-cycle scan request (master -> scanner)
//   y_in             : circuit output, combinational from bcd_out (master -> scanner)
//   bcd_out          : {B,C,D} drive vector (scanner -> master)
//   busy, done, pass : scan status (scanner -> master)
//   table_out        : captured truth table (scanner -> master)
//   mismatch         : table_out ^ expected table (scanner -> master)
//   fail_sticky      : latched failure flag, present only when
//                      SCANNER_CONTINUOUS_EN is defined
interface truth_table_scanner_if #(
  parameter int N_IN = 3
);
  localparam int TW = 2**N_IN;

  logic            start;
  logic            y_in;
  logic [N_IN-1:0] bcd_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [TW-1:0]   table_out;
  logic [TW-1:0]   mismatch;
`ifdef SCANNER_CONTINUOUS_EN
  logic            fail_sticky;

  modport master (
    output start, y_in,
    input  bcd_out, busy, done, pass, table_out, mismatch, fail_sticky
  );
  modport slave (
    input  start, y_in,
    output bcd_out, busy, done, pass, table_out, mismatch, fail_sticky
  );
`else
  modport master (
    output start, y_in,
    input  bcd_out, busy, done, pass, table_out, mismatch
  );
  modport slave (
    input  start, y_in,
    output bcd_out, busy, done, pass, table_out, mismatch
  );
`endif

endinterface

// File: rtl/truth_table_scanner_settle_timer.sv
// scan_settle_timer: loadable down-counter that times how long bcd_out is
// held before y_in is sampled.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   i_load   : load i_val (takes priority over counting)
//   i_val    : load value
//   o_expire : high during the last counted cycle (count == 1)
// Loaded on the edge that enters DRIVE with the settle length L, it reads
// L, L-1, ..., 1, so o_expire rises on the L-th DRIVE cycle.
module scan_settle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_expire
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst)                r_cnt <= '0;
    else if (i_load)        r_cnt <= i_val;
    else if (r_cnt != '0)   r_cnt <= r_cnt - W'(1);
  end

  assign o_expire = (r_cnt == W'(1));

endmodule

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: steps a circuit-under-test through every input code
// {B,C,D} = 0 .. 2^N_IN-1, samples its output Y after a settle delay, builds
// the truth table and compares it with EXPECTED.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : truth_table_scanner_if.slave (start, y_in in; bcd_out, busy, done,
//          pass, table_out, mismatch [, fail_sticky] out)
// Parameters: N_IN (1..6), SETTLE_CYCLES (>= 1), EXPECTED (2^N_IN bits).
// Build option SCANNER_CONTINUOUS_EN: DONE loops straight back to DRIVE so
// scans repeat forever after the first start, and fail_sticky latches any
// failing scan until rst. Because DONE costs one cycle, the repeat period is
// 2^N_IN*(SETTLE_CYCLES+1)+1 clocks.
module truth_table_scanner
  import scanner_pkg::*;
#(
  parameter int                     N_IN          = 3,
  parameter int                     SETTLE_CYCLES = 1,
  parameter logic [(2**N_IN)-1:0]   EXPECTED      = 8'b1010_0010
) (
  input logic                   clk,
  input logic                   rst,
  truth_table_scanner_if.slave  bus
);

  localparam int                TBL_W    = table_w(N_IN);
  localparam int                CNT_W    = settle_w(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]  SETTLE_V = CNT_W'(SETTLE_CYCLES);
  localparam logic [N_IN-1:0]   LAST     = N_IN'(TBL_W - 1);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("truth_table_scanner: SETTLE_CYCLES must be at least 1");
  end
  if (N_IN < 1 || N_IN > 6) begin : g_bad_nin
    $error("truth_table_scanner: N_IN must be in 1..6");
  end

  state_t           r_state;
  logic [N_IN-1:0]  r_idx;      // current code; doubles as bcd_out
  logic [TBL_W-1:0] r_table;
  logic [TBL_W-1:0] r_mis;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
`ifdef SCANNER_CONTINUOUS_EN
  logic             r_fail_sticky;
`endif

  logic             w_load;
  logic             w_expire;
  logic             w_last;
  logic [TBL_W-1:0] w_final;

  assign w_last = (r_idx == LAST);

  // Table including the sample being taken this cycle, so pass/mismatch can
  // be registered on the same edge that writes the last bit.
  always_comb begin
    w_final        = r_table;
    w_final[r_idx] = bus.y_in;
  end

  // Reload the settle timer on every edge that enters DRIVE.
  always_comb begin
    w_load = 1'b0;
    case (r_state)
      IDLE:    w_load = bus.start;
      SAMPLE:  w_load = !w_last;
`ifdef SCANNER_CONTINUOUS_EN
      DONE:    w_load = 1'b1;
`endif
      default: w_load = 1'b0;
    endcase
  end

  scan_settle_timer #(.W(CNT_W)) u_settle (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_val    (SETTLE_V),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_table       <= '0;
      r_mis         <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
`ifdef SCANNER_CONTINUOUS_EN
      r_fail_sticky <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state <= DRIVE;
            r_idx   <= '0;
            r_table <= '0;
            r_mis   <= '0;
            r_pass  <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        DRIVE: begin
          if (w_expire) r_state <= SAMPLE;
        end
        SAMPLE: begin
          r_table <= w_final;
          if (w_last) begin
            // index stays at the last code; no wrap
            r_state <= DONE;
            r_done  <= 1'b1;
            r_pass  <= (w_final == EXPECTED);
            r_mis   <= w_final ^ EXPECTED;
`ifdef SCANNER_CONTINUOUS_EN
            if (w_final != EXPECTED) r_fail_sticky <= 1'b1;
`endif
          end else begin
            r_idx   <= r_idx + N_IN'(1);
            r_state <= DRIVE;
          end
        end
        DONE: begin
          // start seen here is dropped: the scanner is still busy
          r_idx <= '0;
`ifdef SCANNER_CONTINUOUS_EN
          r_state <= DRIVE;
          r_table <= '0;
`else
          r_state <= IDLE;
          r_busy  <= 1'b0;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.bcd_out     = r_idx;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.pass        = r_pass;
  assign bus.table_out   = r_table;
  assign bus.mismatch    = r_mis;
`ifdef SCANNER_CONTINUOUS_EN
  assign bus.fail_sticky = r_fail_sticky;
`endif

endmodule
